wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 115 +++++++++++
 tb/tb_wb_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Writeback queue: merges load and ALU results into one register-file write port,
// in acceptance order, and answers decode-stage hazard queries against pending writes.
module wb_queue #(
  parameter int unsigned n     = 32,
  parameter int unsigned r     = 7,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         memValid,
  input  logic [r-1:0] memReg,
  input  logic [n-1:0] memData,
  output logic         memReady,
  input  logic         aluValid,
  input  logic [r-1:0] aluReg,
  input  logic [n-1:0] aluData,
  output logic         aluReady,
  output logic         regWrite,
  output logic [r-1:0] writeReg,
  output logic [n-1:0] writeData,
  input  logic [r-1:0] lookupReg,
  output logic         lookupHit,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [r-1:0]  regs_q [DEPTH];
  logic [n-1:0]  data_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          reg_write_q, reg_write_d;
  logic [r-1:0]  write_reg_q, write_reg_d;
  logic [n-1:0]  write_data_q, write_data_d;

  logic          mem_push, alu_push, pop;
  logic [CW-1:0] n_push;
  logic [AW-1:0] alu_idx;
  logic [AW-1:0] off;

  // Readiness looks only at registered count; mem owns the last free slot.
  always_comb begin
    memReady = (count_q < CW'(DEPTH));
    aluReady = (count_q < CW'(DEPTH - 1)) ||
               ((count_q == CW'(DEPTH - 1)) && !memValid);
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
  end

  always_comb begin
    mem_push     = memValid && memReady;
    alu_push     = aluValid && aluReady;
    pop          = (count_q != '0);
    n_push       = CW'(mem_push) + CW'(alu_push);
    count_d      = count_q + n_push - CW'(pop);
    tail_d       = tail_q + AW'(n_push);
    head_d       = head_q + AW'(pop);
    alu_idx      = mem_push ? (tail_q + AW'(1)) : tail_q;
    reg_write_d  = pop;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (pop) begin
      write_reg_d  = regs_q[head_q];
      write_data_d = data_q[head_q];
    end
  end

  // Storage is not reset; validity is defined by head/count alone.
  always_ff @(posedge clk) begin
    if (mem_push) begin
      regs_q[tail_q] <= memReg;
      data_q[tail_q] <= memData;
    end
    if (alu_push) begin
      regs_q[alu_idx] <= aluReg;
      data_q[alu_idx] <= aluData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign regWrite  = reg_write_q;
  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;

  // Hazard hit: any live slot (offset from head below count) or the write in flight.
  always_comb begin
    off       = '0;
    lookupHit = reg_write_q && (write_reg_q == lookupReg);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = AW'(i) - head_q;
      if ((CW'(off) < count_q) && (regs_q[i] == lookupReg)) lookupHit = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: queue-based reference model checked every cycle, plus
// hand-computed directed expectations for the key scenarios.
module tb_wb_queue;
  localparam int unsigned N = 32;
  localparam int unsigned R = 7;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         memValid, aluValid;
  logic [R-1:0] memReg, aluReg, lookupReg;
  logic [N-1:0] memData, aluData;
  logic         memReady, aluReady, regWrite, lookupHit, full, empty;
  logic [R-1:0] writeReg;
  logic [N-1:0] writeData;

  int checks = 0;
  int failures = 0;

  wb_queue #(.n(N), .r(R), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .memValid(memValid), .memReg(memReg), .memData(memData), .memReady(memReady),
    .aluValid(aluValid), .aluReg(aluReg), .aluData(aluData), .aluReady(aluReady),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .lookupReg(lookupReg), .lookupHit(lookupHit), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [R-1:0] rg;
    logic [N-1:0] dt;
  } ent_t;

  ent_t         mq[$];
  logic         exp_rw = 1'b0;
  logic [R-1:0] exp_wr = '0;
  logic [N-1:0] exp_wd = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: pop the oldest entry (pre-edge size), then append accepted requests mem-first.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_rw = 1'b0;
      exp_wr = '0;
      exp_wd = '0;
    end else begin
      int   sz;
      logic mr, ar;
      ent_t e;
      sz = mq.size();
      mr = (sz < D);
      ar = (sz < D - 1) || ((sz == D - 1) && !memValid);
      if (sz > 0) begin
        e      = mq.pop_front();
        exp_rw = 1'b1;
        exp_wr = e.rg;
        exp_wd = e.dt;
      end else begin
        exp_rw = 1'b0;
      end
      if (memValid && mr) mq.push_back('{rg: memReg, dt: memData});
      if (aluValid && ar) mq.push_back('{rg: aluReg, dt: aluData});
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int   sz;
    logic hit;
    sz  = mq.size();
    hit = exp_rw && (exp_wr == lookupReg);
    foreach (mq[i]) if (mq[i].rg == lookupReg) hit = 1'b1;
    chk("m_memReady", 64'(memReady), 64'(sz < D));
    chk("m_aluReady", 64'(aluReady), 64'((sz < D - 1) || ((sz == D - 1) && !memValid)));
    chk("m_full", 64'(full), 64'(sz == D));
    chk("m_empty", 64'(empty), 64'(sz == 0));
    chk("m_regWrite", 64'(regWrite), 64'(exp_rw));
    chk("m_writeReg", 64'(writeReg), 64'(exp_wr));
    chk("m_writeData", 64'(writeData), 64'(exp_wd));
    chk("m_lookupHit", 64'(lookupHit), 64'(hit));
  end

  task automatic set_in(input logic mv, input int mr, input int md,
                        input logic av, input int ar, input int ad);
    memValid = mv;
    memReg   = R'(mr);
    memData  = N'(md);
    aluValid = av;
    aluReg   = R'(ar);
    aluData  = N'(ad);
  endtask

  task automatic idle();
    set_in(1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    lookupReg = '0;
    #2;
    chk("rst_regWrite", 64'(regWrite), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_memReady", 64'(memReady), 64'd1);
    chk("rst_aluReady", 64'(aluReady), 64'd1);
    chk("rst_lookupHit", 64'(lookupHit), 64'd0);
    chk("rst_writeData", 64'(writeData), 64'd0);
    #10 rst_n = 1'b1;
    tick();

    // Single ALU write: emitted in the cycle after the second edge.
    set_in(1'b0, 0, 0, 1'b1, 5, 'h1234);
    tick();
    idle();
    chk("alu1_empty", 64'(empty), 64'd0);
    chk("alu1_rw_e1", 64'(regWrite), 64'd0);
    tick();
    chk("alu1_rw", 64'(regWrite), 64'd1);
    chk("alu1_reg", 64'(writeReg), 64'd5);
    chk("alu1_data", 64'(writeData), 64'h1234);
    tick();
    chk("alu1_rw_off", 64'(regWrite), 64'd0);
    chk("alu1_hold", 64'(writeData), 64'h1234);

    // Same-edge mem and ALU to reg 3: mem emitted first.
    set_in(1'b1, 3, 'hAAAA, 1'b1, 3, 'hBBBB);
    tick();
    idle();
    tick();
    chk("both_rw1", 64'(regWrite), 64'd1);
    chk("both_d1", 64'(writeData), 64'hAAAA);
    tick();
    chk("both_rw2", 64'(regWrite), 64'd1);
    chk("both_r2", 64'(writeReg), 64'd3);
    chk("both_d2", 64'(writeData), 64'hBBBB);
    tick();
    chk("both_rw_off", 64'(regWrite), 64'd0);

    // Build count to 3, then contend for the last slot.
    set_in(1'b1, 1, 'h11, 1'b1, 2, 'h22);
    tick();
    set_in(1'b1, 3, 'h33, 1'b1, 4, 'h44);
    tick();
    set_in(1'b1, 5, 'h55, 1'b1, 6, 'h66);
    #1;
    chk("last_memReady", 64'(memReady), 64'd1);
    chk("last_aluReady", 64'(aluReady), 64'd0);
    chk("last_wr1", 64'(writeReg), 64'd1);
    tick();
    idle();
    chk("last_full", 64'(full), 64'd0);
    chk("last_wr2", 64'(writeReg), 64'd2);
    for (int k = 3; k <= 5; k++) begin
      tick();
      chk("last_order", 64'(writeReg), 64'(k));
    end
    tick();
    chk("last_drained", 64'(regWrite), 64'd0);
    chk("last_empty", 64'(empty), 64'd1);

    // Regs 1..4 in order through wrapped pointers.
    set_in(1'b1, 1, 'h101, 1'b1, 2, 'h102);
    tick();
    set_in(1'b1, 3, 'h103, 1'b1, 4, 'h104);
    tick();
    idle();
    chk("fill_wr1", 64'(writeReg), 64'd1);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("fill_order", 64'(writeData), 64'('h100 + k));
    end
    chk("fill_empty", 64'(empty), 64'd1);

    // Hazard lookup on a queued reg 7, through its write cycle.
    set_in(1'b0, 0, 0, 1'b1, 7, 'h77);
    lookupReg = R'(7);
    tick();
    idle();
    chk("hit_q7", 64'(lookupHit), 64'd1);
    lookupReg = R'(8);
    #1;
    chk("hit_q8", 64'(lookupHit), 64'd0);
    lookupReg = R'(7);
    tick();
    chk("hit_rw7", 64'(lookupHit), 64'd1);
    chk("hit_rw_reg", 64'(writeReg), 64'd7);
    tick();
    chk("hit_gone", 64'(lookupHit), 64'd0);

    // Mid-operation reset with two entries queued and a write in flight.
    set_in(1'b1, 10, 'hA0, 1'b1, 11, 'hA1);
    tick();
    set_in(1'b1, 12, 'hA2, 1'b1, 13, 'hA3);
    tick();
    idle();
    tick();
    lookupReg = R'(12);
    #1;
    chk("pre_rst_rw", 64'(regWrite), 64'd1);
    chk("pre_rst_hit", 64'(lookupHit), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_rw", 64'(regWrite), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_hit", 64'(lookupHit), 64'd0);
    chk("arst_wreg", 64'(writeReg), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b0, 0, 0, 1'b1, 20, 'h2020);
    tick();
    idle();
    chk("rel_accept", 64'(empty), 64'd0);
    chk("rel_no_stale", 64'(regWrite), 64'd0);
    tick();
    chk("rel_rw", 64'(regWrite), 64'd1);
    chk("rel_reg", 64'(writeReg), 64'd20);
    tick();
    chk("rel_rw_off", 64'(regWrite), 64'd0);

    // Mixed traffic, covered by the per-cycle model compare.
    for (int k = 0; k < 300; k++) begin
      set_in(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom));
      lookupReg = R'($urandom_range(0, 7));
      tick();
    end
    idle();
    repeat (8) tick();
    chk("end_empty", 64'(empty), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
